// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst writer: drains a stream FIFO into a linear memory buffer
// using incrementing-address bursts, one buffer transfer per start pulse.
module wb_stream_writer_ctrl #(
   parameter int WB_AW   = 32,
   parameter int WB_DW   = 32,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic [WB_AW-1:0]   wbm_adr_o,
   output logic [WB_DW-1:0]   wbm_dat_o,
   output logic [WB_DW/8-1:0] wbm_sel_o,
   output logic               wbm_we_o,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic [2:0]         wbm_cti_o,
   output logic [1:0]         wbm_bte_o,
   input  logic [WB_DW-1:0]   wbm_dat_i,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i,
   input  logic [WB_DW-1:0]   fifo_d_i,
   input  logic               fifo_valid_i,
   output logic               fifo_ready_o,
   input  logic [FIFO_AW:0]   fifo_cnt_i,
   input  logic               start_i,
   input  logic [WB_AW-1:0]   start_adr_i,
   input  logic [WB_AW-1:0]   buf_size_i,
   input  logic [7:0]         burst_size_i,
   output logic               busy_o,
   output logic               irq_o,
   output logic               err_o,
   output logic [WB_AW-1:0]   tx_cnt_o
);

   localparam int SW = WB_DW / 8;
   localparam int CW = FIFO_AW + 1;
   localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   // Next burst is the configured size unless fewer words remain.
   function automatic logic [7:0] burst_len(input logic [7:0] bs, input logic [WB_AW-1:0] remain);
      logic [7:0] len;
      if (WB_AW'(bs) < remain) begin
         len = bs;
      end else begin
         len = remain[7:0];
      end
      return len;
   endfunction

   state_t           r_state;
   logic [WB_AW-1:0] r_base_adr;
   logic [WB_AW-1:0] r_buf_size;
   logic [7:0]       r_burst_size;
   logic [7:0]       r_len;
   logic [7:0]       r_beat;
   logic [WB_AW-1:0] r_tx_cnt;
   logic             r_cyc;
   logic             r_busy;
   logic             r_irq;
   logic             r_err;

   logic [7:0]       w_bs_eff;
   logic [CW-1:0]    w_thresh;
   logic             w_stb;
   logic             w_accept;
   logic             w_last;
   logic [WB_AW-1:0] w_tx_next;
   logic [WB_AW-1:0] w_adr;
   logic             w_unused_dat;

   assign w_unused_dat = ^wbm_dat_i;
   assign w_bs_eff     = (burst_size_i == 8'd0) ? 8'd1 : burst_size_i;
   assign w_stb        = r_cyc & fifo_valid_i;
   assign w_accept     = w_stb & wbm_ack_i & ~wbm_err_i;
   assign w_last       = (r_beat == (r_len - 8'd1));
   assign w_tx_next    = r_tx_cnt + WB_AW'(1);
   assign w_adr        = r_base_adr + (r_tx_cnt << 2);

   // A burst longer than the FIFO can hold starts once the FIFO is full.
   always_comb begin
      w_thresh = FIFO_DEPTH;
      if (32'(r_len) <= 32'(FIFO_DEPTH)) begin
         w_thresh = CW'(r_len);
      end else begin
         w_thresh = FIFO_DEPTH;
      end
   end

   // Transfer sequencer: IDLE -> WAIT (FIFO fill) -> BURST (bus beats).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_base_adr   <= {WB_AW{1'b0}};
         r_buf_size   <= {WB_AW{1'b0}};
         r_burst_size <= 8'd0;
         r_len        <= 8'd0;
         r_beat       <= 8'd0;
         r_tx_cnt     <= {WB_AW{1'b0}};
         r_cyc        <= 1'b0;
         r_busy       <= 1'b0;
         r_irq        <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cyc <= 1'b0;
               if (start_i) begin
                  r_base_adr   <= start_adr_i;
                  r_buf_size   <= buf_size_i;
                  r_burst_size <= w_bs_eff;
                  r_tx_cnt     <= {WB_AW{1'b0}};
                  r_err        <= 1'b0;
                  r_beat       <= 8'd0;
                  if (buf_size_i == {WB_AW{1'b0}}) begin
                     r_irq <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_len   <= burst_len(w_bs_eff, buf_size_i);
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (fifo_cnt_i >= w_thresh) begin
                  r_cyc   <= 1'b1;
                  r_beat  <= 8'd0;
                  r_state <= S_BURST;
               end
            end
            S_BURST: begin
               if (wbm_err_i) begin
                  r_cyc   <= 1'b0;
                  r_err   <= 1'b1;
                  r_irq   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  r_tx_cnt <= w_tx_next;
                  if (w_last) begin
                     r_cyc <= 1'b0;
                     if (w_tx_next == r_buf_size) begin
                        r_irq   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end else begin
                        r_len   <= burst_len(r_burst_size, r_buf_size - w_tx_next);
                        r_state <= S_WAIT;
                     end
                  end else begin
                     r_beat <= r_beat + 8'd1;
                  end
               end
            end
            default: begin
               r_cyc   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign wbm_adr_o    = r_cyc ? w_adr : {WB_AW{1'b0}};
   assign wbm_dat_o    = r_cyc ? fifo_d_i : {WB_DW{1'b0}};
   assign wbm_sel_o    = r_cyc ? {SW{1'b1}} : {SW{1'b0}};
   assign wbm_we_o     = r_cyc;
   assign wbm_cyc_o    = r_cyc;
   assign wbm_stb_o    = w_stb;
   assign wbm_cti_o    = r_cyc ? (w_last ? 3'b111 : 3'b010) : 3'b000;
   assign wbm_bte_o    = 2'b00;
   assign fifo_ready_o = w_accept;
   assign busy_o       = r_busy;
   assign irq_o        = r_irq;
   assign err_o        = r_err;
   assign tx_cnt_o     = r_tx_cnt;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Bench for wb_stream_writer_ctrl: a queue-based FIFO and Wishbone slave drive
// the DUT; every accepted beat is checked against the buffer/burst layout.
module tb_wb_stream_writer_ctrl;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i;
   logic [31:0] fifo_d_i;
   logic        fifo_valid_i, fifo_ready_o;
   logic [4:0]  fifo_cnt_i;
   logic        start_i;
   logic [31:0] start_adr_i, buf_size_i;
   logic [7:0]  burst_size_i;
   logic        busy_o, irq_o, err_o;
   logic [31:0] tx_cnt_o;

   always #5 clk = ~clk;

   wb_stream_writer_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
      .clk(clk), .rst(rst),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .fifo_d_i(fifo_d_i), .fifo_valid_i(fifo_valid_i), .fifo_ready_o(fifo_ready_o),
      .fifo_cnt_i(fifo_cnt_i), .start_i(start_i), .start_adr_i(start_adr_i),
      .buf_size_i(buf_size_i), .burst_size_i(burst_size_i),
      .busy_o(busy_o), .irq_o(irq_o), .err_o(err_o), .tx_cnt_o(tx_cnt_o)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc_n = 0;
   logic [31:0] q[$];
   logic [31:0] m_base = 32'd0;
   logic [31:0] m_size = 32'd0;
   int          m_bs = 1, m_idx = 0;
   int          beat_cnt = 0, burst_cnt = 0, irq_cnt = 0;
   int          irq_cyc = -1, last_beat_cyc = -1, err_cyc = -1;
   logic        cyc_at_irq = 1'b0;
   logic        prev_cyc = 1'b0;
   bit          ack_rand = 1'b0, prod_en = 1'b0;
   int          err_at = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Beat idx closes a burst when it ends a chunk of m_bs words or the buffer.
   function automatic logic [2:0] exp_cti(input int idx);
      if (((idx + 1) % m_bs == 0) || (idx + 1 == int'(m_size))) return 3'b111;
      return 3'b010;
   endfunction

   task automatic drive_fifo();
      fifo_valid_i = (q.size() > 0);
      fifo_d_i     = (q.size() > 0) ? q[0] : 32'h0;
      fifo_cnt_i   = 5'(q.size());
   endtask

   task automatic prefill(input int n);
      for (int i = 0; i < n; i++) q.push_back($urandom);
      drive_fifo();
   endtask

   task automatic tick();
      bit popped;
      popped = 1'b0;
      #1;
      if (!rst) begin
         if (!wbm_cyc_o)
            chk("quiet_outside_burst", 64'({wbm_stb_o, wbm_we_o, fifo_ready_o}), 64'(3'b000));
         if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
            chk("beat_adr", 64'(wbm_adr_o), 64'(m_base + 32'(4 * m_idx)));
            chk("beat_dat", 64'(wbm_dat_o), 64'((q.size() > 0) ? q[0] : 32'hDEAD_BEEF));
            chk("beat_cti", 64'(wbm_cti_o), 64'(exp_cti(m_idx)));
            chk("beat_ctl", 64'({wbm_sel_o, wbm_we_o, wbm_bte_o, fifo_ready_o}),
                64'({4'hF, 1'b1, 2'b00, 1'b1}));
            m_idx++;
            beat_cnt++;
            last_beat_cyc = cyc_n;
            popped = 1'b1;
         end else if (wbm_cyc_o) begin
            chk("no_pop_without_ack", 64'(fifo_ready_o), 64'(1'b0));
         end
         if (wbm_cyc_o && wbm_err_i) err_cyc = cyc_n;
         if (wbm_cyc_o && !prev_cyc) burst_cnt++;
         if (irq_o) begin
            irq_cnt++;
            irq_cyc    = cyc_n;
            cyc_at_irq = wbm_cyc_o;
         end
      end
      prev_cyc = wbm_cyc_o;
      @(posedge clk);
      #1;
      cyc_n++;
      if (popped) void'(q.pop_front());
      if (prod_en && q.size() < DEPTH && $urandom_range(0, 1) == 1) q.push_back($urandom);
      wbm_ack_i = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      wbm_err_i = 1'b0;
      if (err_at >= 0 && m_idx == err_at && wbm_cyc_o) begin
         wbm_err_i = 1'b1;
         wbm_ack_i = 1'b0;
         err_at    = -1;
      end
      drive_fifo();
   endtask

   task automatic start_xfer(input logic [31:0] adr, input logic [31:0] size, input logic [7:0] bs);
      start_adr_i  = adr;
      buf_size_i   = size;
      burst_size_i = bs;
      start_i      = 1'b1;
      m_base    = adr;
      m_size    = size;
      m_bs      = (bs == 8'd0) ? 1 : int'(bs);
      m_idx     = 0;
      beat_cnt  = 0;
      burst_cnt = 0;
      tick();
      start_i = 1'b0;
   endtask

   task automatic run_to_done(input string tag, input int budget, input int exp_tx, input bit is_err);
      int n;
      int base;
      n    = 0;
      base = irq_cnt;
      while (irq_cnt == base && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_irq_seen"}, 64'(irq_cnt != base), 64'(1'b1));
      if (is_err) chk({tag, "_irq_after_err"}, 64'(irq_cyc), 64'(err_cyc + 1));
      else        chk({tag, "_irq_after_last"}, 64'(irq_cyc), 64'(last_beat_cyc + 1));
      chk({tag, "_cyc_low_at_irq"}, 64'(cyc_at_irq), 64'(1'b0));
      tick();
      tick();
      chk({tag, "_irq_single"}, 64'(irq_cnt - base), 64'(1));
      chk({tag, "_busy"}, 64'(busy_o), 64'(1'b0));
      chk({tag, "_tx_cnt"}, 64'(tx_cnt_o), 64'(exp_tx));
      chk({tag, "_beats"}, 64'(beat_cnt), 64'(exp_tx));
      chk({tag, "_err"}, 64'(err_o), 64'(is_err));
      if (!is_err)
         chk({tag, "_bursts"}, 64'(burst_cnt), 64'((int'(m_size) + m_bs - 1) / m_bs));
   endtask

   initial begin
      rst = 1'b1;
      wbm_dat_i = 32'h0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      start_i = 1'b0; start_adr_i = 32'h0; buf_size_i = 32'h0; burst_size_i = 8'h0;
      drive_fifo();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, irq_o, err_o, fifo_ready_o}), 64'(7'd0));
      chk("reset_adr", 64'(wbm_adr_o), 64'(0));
      chk("reset_tx_cnt", 64'(tx_cnt_o), 64'(0));
      chk("reset_cti_sel", 64'({wbm_cti_o, wbm_sel_o, wbm_bte_o}), 64'(0));
      rst = 1'b0;
      tick();

      // Two full bursts from a pre-filled FIFO, ack every cycle.
      prefill(8);
      start_xfer(32'h1000, 32'd8, 8'd4);
      chk("two_bursts_busy", 64'(busy_o), 64'(1'b1));
      run_to_done("two_bursts", 100, 8, 1'b0);

      // Short tail burst of one beat, random ack.
      ack_rand = 1'b1;
      prefill(5);
      start_xfer(32'h2000, 32'd5, 8'd4);
      run_to_done("short_tail", 200, 5, 1'b0);
      ack_rand = 1'b0;

      // FIFO one word short of the burst holds the controller in WAIT.
      prefill(3);
      start_xfer(32'h6000, 32'd4, 8'd4);
      repeat (8) tick();
      chk("fill_wait_cyc", 64'(wbm_cyc_o), 64'(1'b0));
      chk("fill_wait_busy", 64'(busy_o), 64'(1'b1));
      prefill(1);
      tick();
      chk("fill_go_cyc", 64'(wbm_cyc_o), 64'(1'b1));
      run_to_done("fill_go", 100, 4, 1'b0);

      // Bus error on the third beat aborts the transfer.
      prefill(8);
      err_at = 2;
      start_xfer(32'h1000, 32'd8, 8'd4);
      run_to_done("bus_err", 100, 2, 1'b1);
      chk("bus_err_no_pop", 64'(q.size()), 64'(6));
      start_xfer(32'h7000, 32'd6, 8'd3);
      chk("restart_clears_err", 64'(err_o), 64'(1'b0));
      run_to_done("after_err", 100, 6, 1'b0);

      // Reset mid-burst after two accepted beats.
      prefill(8);
      start_xfer(32'h3000, 32'd8, 8'd4);
      for (int n = 0; n < 50 && m_idx < 2; n++) tick();
      chk("pre_rst_cyc", 64'(wbm_cyc_o), 64'(1'b1));
      chk("pre_rst_tx_cnt", 64'(tx_cnt_o), 64'(2));
      rst = 1'b1;
      #1;
      chk("async_rst_ctl", 64'({wbm_cyc_o, wbm_stb_o, busy_o, fifo_ready_o}), 64'(4'd0));
      chk("async_rst_tx_cnt", 64'(tx_cnt_o), 64'(0));
      chk("async_rst_adr", 64'(wbm_adr_o), 64'(0));
      tick();
      tick();
      rst = 1'b0;
      start_xfer(32'h3000, 32'd2, 8'd2);
      run_to_done("after_rst", 100, 2, 1'b0);
      q.delete();
      drive_fifo();

      // Zero-length start: irq only, no bus activity.
      start_xfer(32'h8000, 32'd0, 8'd4);
      #1;
      chk("zero_len_irq", 64'(irq_o), 64'(1'b1));
      chk("zero_len_busy_cyc", 64'({busy_o, wbm_cyc_o}), 64'(2'b00));
      tick();
      #1;
      chk("zero_len_irq_pulse", 64'(irq_o), 64'(1'b0));

      // Start while busy is ignored.
      start_xfer(32'h4000, 32'd4, 8'd4);
      repeat (3) tick();
      start_adr_i = 32'h5000; buf_size_i = 32'd1; burst_size_i = 8'd1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("busy_start_ignored", 64'({busy_o, wbm_cyc_o}), 64'(2'b10));
      chk("busy_start_tx_cnt", 64'(tx_cnt_o), 64'(0));
      prefill(4);
      run_to_done("busy_start", 100, 4, 1'b0);

      // Randomized transfers with a live producer and random acks.
      ack_rand = 1'b1;
      prod_en  = 1'b1;
      for (int t = 0; t < 10; t++) begin
         logic [31:0] adr;
         logic [31:0] sz;
         logic [7:0]  bs;
         adr = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         sz  = 32'($urandom_range(1, 20));
         bs  = 8'($urandom_range(0, 20));
         start_xfer(adr, sz, bs);
         run_to_done("random_xfer", 3000, int'(sz), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_stream_writer_ctrl.md
WB_STREAM_WRITER_CTRL -- requirements
Module: wb_stream_writer_ctrl

Interface
REQ-001 SHALL have parameter WB_AW, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, meaning Wishbone data width and FIFO word width.
REQ-003 SHALL have parameter FIFO_AW, default 4, meaning depth width of the attached FIFO; fill count is FIFO_AW+1 bits.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-005 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have: wbm_adr_o out WB_AW byte address; wbm_dat_o out WB_DW write data; wbm_sel_o out WB_DW/8 byte select; wbm_we_o out 1; wbm_cyc_o out 1; wbm_stb_o out 1; wbm_cti_o out 3; wbm_bte_o out 2.
REQ-007 SHALL have: wbm_dat_i in WB_DW (unused); wbm_ack_i in 1 beat accept; wbm_err_i in 1 bus error.
REQ-008 SHALL have: fifo_d_i in WB_DW stream data; fifo_valid_i in 1; fifo_ready_o out 1 (pop strobe); fifo_cnt_i in FIFO_AW+1 FIFO fill level.
REQ-009 SHALL have: start_i in 1 start pulse; start_adr_i in WB_AW buffer byte base address; buf_size_i in WB_AW buffer length in words; burst_size_i in 8 words per burst.
REQ-010 SHALL have: busy_o out 1; irq_o out 1 one-cycle done pulse; err_o out 1 sticky error; tx_cnt_o out WB_AW words written in current transfer.

Function
REQ-011 SHALL implement states IDLE, WAIT, BURST.
REQ-012 SHALL, in IDLE on start_i=1, latch start_adr_i, buf_size_i, burst_size_i (0 treated as 1), clear tx_cnt_o and err_o, set busy_o, and go to WAIT next cycle.
REQ-013 SHALL, on start_i with buf_size_i=0, not enter WAIT; assert irq_o one cycle later, busy_o stays 0.
REQ-014 SHALL ignore start_i while busy_o=1.
REQ-015 SHALL compute burst length L = min(latched burst size, buf_size - tx_cnt) on entry to WAIT.
REQ-016 SHALL leave WAIT for BURST when fifo_cnt_i >= L (compared at FIFO_AW+1 width, L saturated to 2^FIFO_AW).
REQ-017 SHALL in BURST drive cyc=1, we=1, sel all ones, bte=2'b00, stb=fifo_valid_i, dat_o=fifo_d_i, adr_o=start_adr + 4*tx_cnt (WB_AW modulo wrap).
REQ-018 SHALL drive cti=3'b010 for non-final beats and 3'b111 on the final beat of a burst (L=1 gives 3'b111 only).
REQ-019 SHALL assert fifo_ready_o = wbm_ack_i & stb in BURST only; each such cycle increments tx_cnt_o by 1.
REQ-020 SHALL, on ack of the final beat, drop cyc/stb next cycle; go to IDLE with irq_o pulse and busy_o=0 if tx_cnt reaches buf_size, else to WAIT.
REQ-021 SHALL keep cyc/stb/we/fifo_ready_o at 0 in IDLE and WAIT.
REQ-022 SHALL, on wbm_err_i in BURST, drop cyc/stb next cycle, set err_o, pulse irq_o, go to IDLE; the errored beat is not popped nor counted.
REQ-023 SHALL hold err_o until next accepted start_i or reset.

Reset
REQ-024 SHALL on rst=1 immediately enter IDLE with all outputs 0, including mid-burst (cyc dropped asynchronously); latched parameters and tx_cnt_o cleared to 0.

Verification
REQ-025 start_adr=0x1000, buf_size=8, burst=4, FIFO pre-filled 8, ack every cycle -> two bursts at 0x1000 and 0x1010, cti 010,010,010,111 each, irq one pulse after 8th ack, tx_cnt=8.
REQ-026 buf_size=5, burst=4 -> bursts of 4 then 1; second burst single beat cti=111 at adr start+0x10; irq after 5th ack.
REQ-027 fifo_cnt held at 3 with burst=4 -> stays WAIT, cyc=0; raise to 4 -> cyc=1 next cycle.
REQ-028 wbm_err_i on beat 3 of first burst -> cyc=0 next cycle, err_o=1, irq pulse, tx_cnt=2; new start clears err_o.
REQ-029 rst asserted mid-burst after 2 acks -> cyc, stb, busy, tx_cnt all 0 same cycle; new start restarts at start_adr.
REQ-030 start_i with buf_size=0 -> irq one cycle later, no bus cycle; start_i while busy -> ignored, latched values unchanged.
